// File: rtl/line_buffer_row_streamer.sv
// rtl/line_buffer_row_streamer.sv - 3-slot row buffer streaming vertical 3-pixel windows
//
// Purpose: responder for the conv2d row-streaming handshake. Loads image rows
// from a raster pixel stream into three row slots and emits one vertically
// aligned column window per column, zero-padding the top edge on a first
// command and the bottom edge on a last command.
//
// Ports:
//   clk, Reset                 clock, asynchronous active-high reset
//   IMAGE_SIZE                 image width N, latched on command acceptance
//   Stream_first/mid/last_row  one-cycle command pulses (first > mid > last)
//   s_tdata/s_tvalid/s_tready  input pixel stream
//   out_top/mid/bot, out_col   window pixels and column index
//   out_valid/out_ready        window handshake
//   Done_1row                  one-cycle completion pulse
//   Input_line_buffer_IDLE     high while the FSM is idle
module line_buffer_row_streamer #(
    parameter int DATA_W  = 16,
    parameter int MAX_IMG = 128
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [7:0]        IMAGE_SIZE,
    input  logic              Stream_first_row,
    input  logic              Stream_mid_row,
    input  logic              Stream_last_row,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] out_top,
    output logic [DATA_W-1:0] out_mid,
    output logic [DATA_W-1:0] out_bot,
    output logic [7:0]        out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              Done_1row,
    output logic              Input_line_buffer_IDLE
);

    localparam int AW = (MAX_IMG > 1) ? $clog2(MAX_IMG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] K_FIRST = 2'd0;
    localparam logic [1:0] K_MID   = 2'd1;
    localparam logic [1:0] K_LAST  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_kind;
    logic [1:0]        r_p_top;
    logic [1:0]        r_p_mid;
    logic [1:0]        r_p_new;
    logic [1:0]        r_rows_left;
    logic [7:0]        r_n;
    logic [7:0]        r_ld_col;
    logic [7:0]        r_em_col;
    logic [7:0]        r_out_col;
    logic [DATA_W-1:0] r_out_top;
    logic [DATA_W-1:0] r_out_mid;
    logic [DATA_W-1:0] r_out_bot;
    logic              r_out_valid;

    logic [DATA_W-1:0] r_mem [0:2][0:MAX_IMG-1];

    logic              w_beat;
    logic [1:0]        w_ld_slot;
    logic              w_issue;
    logic              w_accept;
    logic              w_final_acc;
    logic [AW-1:0]     w_rd_addr;
    logic [DATA_W-1:0] w_rd_top;
    logic [DATA_W-1:0] w_rd_mid;
    logic [DATA_W-1:0] w_rd_bot;

    // With two rows left (first command) the row goes to the centre slot;
    // the last row of any load always lands in the "new" slot.
    assign w_beat      = (r_state == S_LOAD) && s_tvalid;
    assign w_ld_slot   = (r_rows_left == 2'd2) ? r_p_mid : r_p_new;
    assign w_issue     = (r_state == S_EMIT) && (!r_out_valid || out_ready) && (r_em_col < r_n);
    assign w_accept    = r_out_valid && out_ready;
    assign w_final_acc = (r_state == S_EMIT) && w_accept && (r_out_col == r_n - 8'd1);

    assign w_rd_addr = r_em_col[AW-1:0];
    assign w_rd_top  = r_mem[r_p_top][w_rd_addr];
    assign w_rd_mid  = r_mem[r_p_mid][w_rd_addr];
    assign w_rd_bot  = r_mem[r_p_new][w_rd_addr];

    // Row storage carries no reset; its contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_mem[w_ld_slot][r_ld_col[AW-1:0]] <= s_tdata;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_kind      <= K_FIRST;
            r_p_top     <= 2'd0;
            r_p_mid     <= 2'd1;
            r_p_new     <= 2'd2;
            r_rows_left <= 2'd0;
            r_n         <= 8'd0;
            r_ld_col    <= 8'd0;
            r_em_col    <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Stream_first_row || Stream_mid_row || Stream_last_row) begin
                        r_n      <= IMAGE_SIZE;
                        r_ld_col <= 8'd0;
                        r_em_col <= 8'd0;
                        if (Stream_first_row) begin
                            r_kind      <= K_FIRST;
                            r_rows_left <= 2'd2;
                            r_state     <= S_LOAD;
                        end else if (Stream_mid_row) begin
                            r_kind      <= K_MID;
                            r_rows_left <= 2'd1;
                            r_state     <= S_LOAD;
                        end else begin
                            r_kind      <= K_LAST;
                            r_rows_left <= 2'd0;
                            r_state     <= S_EMIT;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        if (r_ld_col == r_n - 8'd1) begin
                            r_ld_col    <= 8'd0;
                            r_rows_left <= r_rows_left - 2'd1;
                            if (r_rows_left == 2'd1) begin
                                r_state <= S_EMIT;
                            end
                        end else begin
                            r_ld_col <= r_ld_col + 8'd1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_issue) begin
                        r_em_col <= r_em_col + 8'd1;
                    end
                    if (w_final_acc) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // After a first row the window centre moves down one row:
                    // row 0 becomes the top and row 1 the centre, the freed slot
                    // receives the next loaded row. Mid rows advance the same way.
                    // A last row ends the frame, so the pointers go home.
                    r_state <= S_IDLE;
                    if (r_kind == K_LAST) begin
                        r_p_top <= 2'd0;
                        r_p_mid <= 2'd1;
                        r_p_new <= 2'd2;
                    end else begin
                        r_p_top <= r_p_mid;
                        r_p_mid <= r_p_new;
                        r_p_new <= r_p_top;
                    end
                end
            endcase
        end
    end

    // Window output register: refills whenever empty or being drained.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_out_valid <= 1'b0;
            r_out_top   <= '0;
            r_out_mid   <= '0;
            r_out_bot   <= '0;
            r_out_col   <= 8'd0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_top   <= (r_kind == K_FIRST) ? '0 : w_rd_top;
            r_out_mid   <= w_rd_mid;
            r_out_bot   <= (r_kind == K_LAST) ? '0 : w_rd_bot;
            r_out_col   <= r_em_col;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

    assign s_tready               = (r_state == S_LOAD);
    assign Done_1row              = (r_state == S_DONE);
    assign Input_line_buffer_IDLE = (r_state == S_IDLE);
    assign out_valid              = r_out_valid;
    assign out_top                = r_out_top;
    assign out_mid                = r_out_mid;
    assign out_bot                = r_out_bot;
    assign out_col                = r_out_col;

endmodule

// File: tb/tb_line_buffer_row_streamer.sv
// tb/tb_line_buffer_row_streamer.sv - self-checking bench for line_buffer_row_streamer
module tb_line_buffer_row_streamer;

    logic        clk = 1'b0;
    logic        Reset;
    logic [7:0]  IMAGE_SIZE;
    logic        Stream_first_row, Stream_mid_row, Stream_last_row;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] out_top, out_mid, out_bot;
    logic [7:0]  out_col;
    logic        out_valid;
    logic        out_ready;
    logic        Done_1row;
    logic        Input_line_buffer_IDLE;

    int n_checks = 0;
    int n_fail   = 0;
    int cr       = 0;   // model: image row at the centre of the current window

    logic [15:0] img [0:127][0:127];

    always #5 clk = ~clk;

    line_buffer_row_streamer #(.DATA_W(16), .MAX_IMG(128)) dut (
        .clk                    (clk),
        .Reset                  (Reset),
        .IMAGE_SIZE             (IMAGE_SIZE),
        .Stream_first_row       (Stream_first_row),
        .Stream_mid_row         (Stream_mid_row),
        .Stream_last_row        (Stream_last_row),
        .s_tdata                (s_tdata),
        .s_tvalid               (s_tvalid),
        .s_tready               (s_tready),
        .out_top                (out_top),
        .out_mid                (out_mid),
        .out_bot                (out_bot),
        .out_col                (out_col),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .Done_1row              (Done_1row),
        .Input_line_buffer_IDLE (Input_line_buffer_IDLE)
    );

    task automatic fill_random(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                img[r][c] = 16'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (s_tready !== 1'b0 || out_valid !== 1'b0 || Done_1row !== 1'b0 ||
            Input_line_buffer_IDLE !== 1'b1 || out_col !== 8'd0 ||
            out_top !== 16'd0 || out_mid !== 16'd0 || out_bot !== 16'd0)
            begin
            n_fail++;
            $display("FAIL %s: got rdy=%b vld=%b done=%b idle=%b col=%0d d=%h/%h/%h, want 0/0/0/1/0 d=0",
                     tag, s_tready, out_valid, Done_1row, Input_line_buffer_IDLE, out_col,
                     out_top, out_mid, out_bot);
        end
    endtask

    // kind: 0 first, 1 mid, 2 last, 3 first+last asserted together (acts as first)
    task automatic run_cmd(input int kind, input int n, input int vpct, input int rpct, input bit stray);
        int ekind, rows, total, fi, wi, cyc, limit, last_acc, dones, src;
        bit prev_stall, stray_done, exp_rdy;
        logic [15:0] feed [$];
        logic [15:0] p_top, p_mid, p_bot, e_top, e_mid, e_bot;
        logic [7:0]  p_col;
        logic        p_vld;

        ekind = (kind == 3) ? 0 : kind;
        if (ekind == 0) cr = 0; else cr = cr + 1;
        rows = (ekind == 0) ? 2 : ((ekind == 1) ? 1 : 0);
        src  = (ekind == 0) ? 0 : cr + 1;
        feed.delete();
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < n; c++)
                feed.push_back(img[src + r][c]);
        total = rows * n;
        limit = (total * 100) / vpct + ((n * 100) / rpct) * 4 + 100;

        @(posedge clk); #1;
        IMAGE_SIZE       = 8'(n);
        Stream_first_row = (kind == 0 || kind == 3);
        Stream_mid_row   = (kind == 1);
        Stream_last_row  = (kind == 2 || kind == 3);
        #1;
        n_checks++;
        if (Input_line_buffer_IDLE !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_before_cmd: got %b, want 1", Input_line_buffer_IDLE);
        end
        @(posedge clk); #1;
        Stream_first_row = 1'b0;
        Stream_mid_row   = 1'b0;
        Stream_last_row  = 1'b0;
        IMAGE_SIZE       = 8'($urandom);
        #1;
        n_checks++;
        if (Input_line_buffer_IDLE !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_cmd: got %b, want 0", Input_line_buffer_IDLE);
        end

        fi = 0; wi = 0; cyc = 0; dones = 0; last_acc = -10;
        prev_stall = 1'b0; stray_done = 1'b0;
        p_top = '0; p_mid = '0; p_bot = '0; p_col = '0; p_vld = 1'b0;
        while (dones == 0 && cyc < limit) begin
            s_tvalid  = (fi < total) && ($urandom_range(99) < vpct);
            s_tdata   = (fi < total) ? feed[fi] : 16'h0;
            out_ready = ($urandom_range(99) < rpct);
            Stream_mid_row = stray && !stray_done && (fi >= 2) && (fi < total);
            if (Stream_mid_row) stray_done = 1'b1;
            #1;
            exp_rdy = (fi < total);
            n_checks++;
            if (s_tready !== exp_rdy) begin
                n_fail++;
                $display("FAIL s_tready beat %0d of %0d: got %b, want %b", fi, total, s_tready, exp_rdy);
            end
            if (s_tvalid && s_tready) fi++;
            if (prev_stall) begin
                n_checks++;
                if ({out_valid, out_col, out_top, out_mid, out_bot} !== {p_vld, p_col, p_top, p_mid, p_bot}) begin
                    n_fail++;
                    $display("FAIL stall_hold row %0d: got col %0d %h/%h/%h, want col %0d %h/%h/%h",
                             cr, out_col, out_top, out_mid, out_bot, p_col, p_top, p_mid, p_bot);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (wi >= n) begin
                    n_fail++;
                    $display("FAIL extra_window row %0d: got col %0d, want none", cr, out_col);
                end else begin
                    e_top = (ekind == 0) ? 16'h0 : img[cr - 1][wi];
                    e_mid = img[cr][wi];
                    e_bot = (ekind == 2) ? 16'h0 : img[cr + 1][wi];
                    if (out_col !== 8'(wi) || out_top !== e_top || out_mid !== e_mid || out_bot !== e_bot) begin
                        n_fail++;
                        $display("FAIL window row %0d: got col %0d %h/%h/%h, want col %0d %h/%h/%h",
                                 cr, out_col, out_top, out_mid, out_bot, wi, e_top, e_mid, e_bot);
                    end
                end
                wi++;
                last_acc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            p_vld = out_valid; p_col = out_col; p_top = out_top; p_mid = out_mid; p_bot = out_bot;
            if (Done_1row) begin
                dones++;
                n_checks++;
                if (cyc != last_acc + 1 || wi != n) begin
                    n_fail++;
                    $display("FAIL done_timing row %0d: got cyc %0d windows %0d, want cyc %0d windows %0d",
                             cr, cyc, wi, last_acc + 1, n);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        Stream_mid_row = 1'b0;
        s_tvalid       = 1'b0;
        out_ready      = 1'b0;
        #1;
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL done_seen row %0d: got %0d pulses in %0d cycles, want 1", cr, dones, cyc);
        end
        n_checks++;
        if (fi != total) begin
            n_fail++;
            $display("FAIL beats_consumed row %0d: got %0d, want %0d", cr, fi, total);
        end
        n_checks++;
        if (Done_1row !== 1'b0 || Input_line_buffer_IDLE !== 1'b1) begin
            n_fail++;
            $display("FAIL after_done row %0d: got done=%b idle=%b, want 0/1", cr, Done_1row, Input_line_buffer_IDLE);
        end
    endtask

    task automatic run_frame(input int n, input int vpct, input int rpct);
        run_cmd(0, n, vpct, rpct, 1'b0);
        for (int r = 1; r < n - 1; r++) run_cmd(1, n, vpct, rpct, 1'b0);
        run_cmd(2, n, vpct, rpct, 1'b0);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        Reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("after_reset_release");
    endtask

    task automatic test_frame_4x4;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 16'(4 * r + c + 1);
        run_frame(4, 100, 100);
    endtask

    task automatic test_backpressure;
        fill_random(8);
        run_frame(8, 70, 50);
    endtask

    task automatic test_ignored_cmds;
        fill_random(8);
        run_cmd(3, 8, 80, 100, 1'b1);
        for (int r = 1; r < 7; r++) run_cmd(1, 8, 80, 100, 1'b1);
        run_cmd(2, 8, 100, 100, 1'b0);
    endtask

    task automatic test_reset_mid_load;
        @(posedge clk); #1;
        IMAGE_SIZE = 8'd8;
        Stream_first_row = 1'b1;
        @(posedge clk); #1;
        Stream_first_row = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'($urandom);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        #1;
        n_checks++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_before_reset: got s_tready %b, want 1", s_tready);
        end
        Reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_load");
        @(posedge clk); #1;
        Reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("after_mid_load_reset");
        fill_random(4);
        run_frame(4, 100, 100);
    endtask

    task automatic test_tvalid_gaps;
        fill_random(16);
        run_frame(16, 35, 100);
    endtask

    task automatic test_back_to_back;
        fill_random(128);
        run_frame(128, 100, 100);
        fill_random(128);
        run_frame(128, 100, 100);
    endtask

    initial begin
        Reset            = 1'b0;
        IMAGE_SIZE       = 8'd0;
        Stream_first_row = 1'b0;
        Stream_mid_row   = 1'b0;
        Stream_last_row  = 1'b0;
        s_tdata          = 16'h0;
        s_tvalid         = 1'b0;
        out_ready        = 1'b0;
        #2;
        test_reset;
        test_frame_4x4;
        test_backpressure;
        test_ignored_cmds;
        test_reset_mid_load;
        test_tvalid_gaps;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
